ysyx_24100005_wbu: RTL

Write-back unit of the NPC core, sitting directly upstream of `ysyx_24100005_RegisterFile` and driving its write port. It accepts one retiring instruction at a time from the execute stage over a valid/ready handshake. For loads it issues a word-aligned data-memory request, waits for the response, then extracts and extends the selected byte or half-word. It presents exactly one register-file write (or a suppressed write for x0 or errors) per accepted instruction.

---
 rtl/ysyx_24100005_pkg.sv | 30 +++
 rtl/ysyx_24100005_wbu_if.sv | 38 +++
 rtl/ysyx_24100005_MuxKeyWithDefault.sv | 22 ++
 rtl/ysyx_24100005_load_ext.sv | 41 ++++
 rtl/ysyx_24100005_wbu.sv | 98 +++++++++
 5 files changed

// File: rtl/ysyx_24100005_pkg.sv
// Shared NPC definitions: write-back FSM encoding, load funct3 codes and
// the load legality check.
package ysyx_24100005_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        WB    = 2'd3
    } wbu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // True for an illegal funct3 or a load whose address breaks natural alignment.
    function automatic logic ld_bad(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            LB, LBU:  bad = 1'b0;
            LH, LHU:  bad = off[0];
            LW:       bad = (off != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_24100005_wbu_if.sv
// Execute-to-WBU handshake, data-memory read port and register-file write port.
// master = the write-back unit, slave = its surroundings.
interface ysyx_24100005_wbu_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rd;
    logic                  in_rd_wen;
    logic                  in_is_load;
    logic [2:0]            in_funct3;
    logic [DATA_WIDTH-1:0] in_alu_res;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  commit;
    logic                  ld_err;

    modport master (
        input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_alu_res,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output in_ready, mem_req_valid, mem_addr,
        output rf_wen, rf_waddr, rf_wdata, commit, ld_err
    );

    modport slave (
        output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_alu_res,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  in_ready, mem_req_valid, mem_addr,
        input  rf_wen, rf_waddr, rf_wdata, commit, ld_err
    );
endinterface

// File: rtl/ysyx_24100005_MuxKeyWithDefault.sv
// Key-matched mux: i_lut packs NR_KEY {key, data} pairs, pair 0 in the LSBs.
// Unmatched keys select i_default.
module ysyx_24100005_MuxKeyWithDefault #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                  i_key,
    input  logic [DATA_LEN-1:0]                 i_default,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] i_lut,
    output logic [DATA_LEN-1:0]                 o_out
);
    localparam int PAIR = KEY_LEN + DATA_LEN;

    always_comb begin
        o_out = i_default;
        for (int i = 0; i < NR_KEY; i++) begin
            if (i_lut[i*PAIR+DATA_LEN +: KEY_LEN] == i_key)
                o_out = i_lut[i*PAIR +: DATA_LEN];
        end
    end
endmodule

// File: rtl/ysyx_24100005_load_ext.sv
// Load-data extract/extend: picks the addressed byte or half-word out of an
// aligned word and sign/zero-extends it according to funct3.
module ysyx_24100005_load_ext
    import ysyx_24100005_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [1:0]            i_off,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    ysyx_24100005_MuxKeyWithDefault #(
        .NR_KEY  (5),
        .KEY_LEN (3),
        .DATA_LEN(DATA_WIDTH)
    ) u_mux (
        .i_key    (i_funct3),
        .i_default({DATA_WIDTH{1'b0}}),
        .i_lut    ({LB,  {{(DATA_WIDTH-8){w_byte[7]}},  w_byte},
                    LH,  {{(DATA_WIDTH-16){w_half[15]}}, w_half},
                    LW,  i_word,
                    LBU, {{(DATA_WIDTH-8){1'b0}},  w_byte},
                    LHU, {{(DATA_WIDTH-16){1'b0}}, w_half}}),
        .o_out    (o_data)
    );
endmodule

// File: rtl/ysyx_24100005_wbu.sv
// NPC write-back unit: retires one instruction per handshake, runs loads through
// data memory. Optional counters: define YSYX_24100005_WBU_PERF_EN.
module ysyx_24100005_wbu
    import ysyx_24100005_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24100005_wbu_if.master bus
`ifdef YSYX_24100005_WBU_PERF_EN
    ,
    output logic [31:0]         perf_retired,
    output logic [31:0]         perf_ld_stall
`endif
);
    wbu_state_t            r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_rd_wen;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_bad;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_bad    = ld_bad(bus.in_funct3, bus.in_alu_res[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = (bus.in_is_load && !w_bad) ? MREQ : WB;
            MREQ:  if (bus.mem_req_ready) w_next = MWAIT;
            MWAIT: if (bus.mem_rsp_valid) w_next = WB;
            WB:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Everything but in_ready comes from registers, so no input reaches an output.
    always_comb begin
        bus.in_ready      = (r_state == IDLE) && !rst;
        bus.mem_req_valid = (r_state == MREQ);
        bus.mem_addr      = {r_addr[DATA_WIDTH-1:2], 2'b00};
        bus.rf_wen        = (r_state == WB) && r_rd_wen && (r_rd != '0) && !r_err;
        bus.rf_waddr      = r_rd;
        bus.rf_wdata      = r_data;
        bus.commit        = (r_state == WB);
        bus.ld_err        = (r_state == WB) && r_err;
    end

    ysyx_24100005_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .i_word  (bus.mem_rdata),
        .i_off   (r_addr[1:0]),
        .i_funct3(r_funct3),
        .o_data  (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd     <= '0;
            r_rd_wen <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_rd     <= bus.in_rd;
            r_rd_wen <= bus.in_rd_wen;
            r_funct3 <= bus.in_funct3;
            r_addr   <= bus.in_alu_res;
            r_data   <= bus.in_alu_res;
            r_err    <= bus.in_is_load && w_bad;
        end else if (r_state == MWAIT && bus.mem_rsp_valid) begin
            r_data   <= w_ld_data;
        end
    end

`ifdef YSYX_24100005_WBU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired  <= '0;
            perf_ld_stall <= '0;
        end else begin
            if (r_state == WB)                        perf_retired  <= perf_retired + 32'd1;
            if (r_state == MREQ || r_state == MWAIT)  perf_ld_stall <= perf_ld_stall + 32'd1;
        end
    end
`endif
endmodule
